// File: rtl/mem_arb_if.sv
// Frame-buffer request/response and Avalon-MM style memory signals of mem_arb.
// slave is the arbiter side; master is the frame buffer plus memory environment.
interface mem_arb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_rdy;
    logic                  rd_rdy;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;
    logic [ADDR_WIDTH-1:0] avl_address;
    logic                  avl_write;
    logic                  avl_read;
    logic [DATA_WIDTH-1:0] avl_writedata;
    logic                  avl_waitrequest;
    logic [DATA_WIDTH-1:0] avl_readdata;
    logic                  avl_readdatavalid;

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  avl_waitrequest, avl_readdata, avl_readdatavalid,
        output wr_rdy, rd_rdy, rd_data, rd_data_valid,
        output avl_address, avl_write, avl_read, avl_writedata
    );

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output avl_waitrequest, avl_readdata, avl_readdatavalid,
        input  wr_rdy, rd_rdy, rd_data, rd_data_valid,
        input  avl_address, avl_write, avl_read, avl_writedata
    );
endinterface

// File: rtl/mem_arb.sv
// Fair write/read arbiter between a frame buffer and a single-port pipelined memory.
// One command in flight at a time; up to MAX_PEND reads may await their data.
module mem_arb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned MAX_PEND   = 4
) (
    input logic     clk,
    input logic     reset,
    mem_arb_if.slave bus
);
    localparam int unsigned PendW = $clog2(MAX_PEND + 1);
    localparam logic [PendW-1:0] PendMax = PendW'(MAX_PEND);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  read_q, read_d;
    logic                  wr_rdy_q, wr_rdy_d;
    logic                  rd_rdy_q, rd_rdy_d;
    logic                  last_rd_q, last_rd_d;
    logic [PendW-1:0]      pend_q, pend_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_elig, rd_elig, rd_accept, rdv_take;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        read_d    = read_q;
        wr_rdy_d  = 1'b0;
        rd_rdy_d  = 1'b0;
        last_rd_d = last_rd_q;
        rd_accept = 1'b0;
        wr_elig   = !bus.wr_en;
        rd_elig   = !bus.rd_en && (pend_q < PendMax);

        unique case (state_q)
            StIdle: begin
                // Under contention the side not granted last wins.
                if (wr_elig && (!rd_elig || last_rd_q)) begin
                    addr_d    = bus.wr_addr;
                    wdata_d   = bus.wr_data;
                    write_d   = 1'b1;
                    last_rd_d = 1'b0;
                    state_d   = StWr;
                end else if (rd_elig) begin
                    addr_d    = bus.rd_addr;
                    read_d    = 1'b1;
                    last_rd_d = 1'b1;
                    state_d   = StRd;
                end
            end
            StWr: begin
                if (!bus.avl_waitrequest) begin
                    write_d  = 1'b0;
                    wr_rdy_d = 1'b1;
                    state_d  = StDone;
                end
            end
            StRd: begin
                if (!bus.avl_waitrequest) begin
                    read_d    = 1'b0;
                    rd_rdy_d  = 1'b1;
                    rd_accept = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Return path runs regardless of the command FSM; data with no read outstanding is dropped.
    always_comb begin
        rdv_take   = bus.avl_readdatavalid && (pend_q != '0);
        rd_valid_d = rdv_take;
        rd_data_d  = rdv_take ? bus.avl_readdata : rd_data_q;
        pend_d     = pend_q;
        unique case ({rd_accept, rdv_take})
            2'b10:   pend_d = pend_q + PendW'(1);
            2'b01:   pend_d = pend_q - PendW'(1);
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            wr_rdy_q   <= 1'b0;
            rd_rdy_q   <= 1'b0;
            last_rd_q  <= 1'b1;
            pend_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            read_q     <= read_d;
            wr_rdy_q   <= wr_rdy_d;
            rd_rdy_q   <= rd_rdy_d;
            last_rd_q  <= last_rd_d;
            pend_q     <= pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.avl_address   = addr_q;
    assign bus.avl_writedata = wdata_q;
    assign bus.avl_write     = write_q;
    assign bus.avl_read      = read_q;
    assign bus.wr_rdy        = wr_rdy_q;
    assign bus.rd_rdy        = rd_rdy_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_valid_q;
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data width of the write, read and memory data buses.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, width of the word address.
REQ-003 SHALL have parameter MAX_PEND, default 4, maximum number of memory reads accepted but not yet returned.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset; it is synchronous and active-low.
REQ-006 SHALL have port wr_en, input, 1, write request from the frame buffer, active-low.
REQ-007 SHALL have port wr_addr, input, ADDR_WIDTH, write word address.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH, write data.
REQ-009 SHALL have port rd_en, input, 1, read request from the frame buffer, active-low.
REQ-010 SHALL have port rd_addr, input, ADDR_WIDTH, read word address.
REQ-011 SHALL have port wr_rdy, output, 1, one-cycle pulse when a write has been accepted by memory.
REQ-012 SHALL have port rd_rdy, output, 1, one-cycle pulse when a read has been accepted by memory.
REQ-013 SHALL have port rd_data, output, DATA_WIDTH, returned read data.
REQ-014 SHALL have port rd_data_valid, output, 1, qualifies rd_data for one cycle.
REQ-015 SHALL have port avl_address, output, ADDR_WIDTH, memory command address.
REQ-016 SHALL have port avl_write, output, 1, memory write command, active-high.
REQ-017 SHALL have port avl_read, output, 1, memory read command, active-high.
REQ-018 SHALL have port avl_writedata, output, DATA_WIDTH, memory write data.
REQ-019 SHALL have port avl_waitrequest, input, 1, memory stall; a command is accepted on an edge where it is low.
REQ-020 SHALL have port avl_readdata, input, DATA_WIDTH, memory read data.
REQ-021 SHALL have port avl_readdatavalid, input, 1, qualifies avl_readdata.

Function
REQ-022 SHALL implement a state machine with states IDLE, WR, RD and DONE, and all outputs SHALL be registered.
REQ-023 In IDLE, a write is eligible when wr_en=0; a read is eligible when rd_en=0 and the pending count is less than MAX_PEND.
REQ-024 When only one request is eligible in IDLE, it SHALL be granted.
REQ-025 When both are eligible, the one not granted last SHALL win; last-grant resets to "read", so the first contended grant goes to the write.
REQ-026 A write grant SHALL, on the same edge, register wr_addr into avl_address and wr_data into avl_writedata, set avl_write=1 and move to WR.
REQ-027 A read grant SHALL, on the same edge, register rd_addr into avl_address, set avl_read=1 and move to RD.
REQ-028 In WR or RD, the command SHALL hold unchanged while avl_waitrequest=1, even if the originating request is withdrawn.
REQ-029 On the edge where avl_waitrequest=0 in WR or RD, the block SHALL clear avl_write/avl_read, pulse wr_rdy/rd_rdy respectively for exactly one cycle, and move to DONE.
REQ-030 DONE SHALL last exactly one cycle and SHALL then go to IDLE.
- Purpose: the frame buffer advances its address on wr_rdy/rd_rdy before IDLE resamples it.
- Result: minimum 3 cycles per transfer; a stale address is never reissued.
REQ-031 The pending count (width clog2(MAX_PEND+1)) SHALL change as follows:
- +1 on read acceptance.
- -1 on avl_readdatavalid.
- Unchanged when both occur on the same edge.
REQ-032 avl_readdatavalid while the pending count is 0 SHALL be ignored: no count change, no rd_data_valid.
REQ-033 Otherwise rd_data SHALL equal avl_readdata with rd_data_valid=1 one cycle after avl_readdatavalid, with no gaps or reordering.
REQ-034 avl_write and avl_read SHALL never be 1 simultaneously, and wr_rdy and rd_rdy SHALL never be 1 simultaneously.
REQ-035 Read-data return SHALL be independent of the state machine; it proceeds during WR, RD, DONE and IDLE.

Reset
REQ-036 With reset=0 at an edge, the block SHALL enter IDLE, clear the pending count and set last-grant to "read".
REQ-037 With reset=0 at an edge, the block SHALL drive avl_write, avl_read, wr_rdy, rd_rdy and rd_data_valid to 0, and rd_data, avl_address and avl_writedata to 0.
REQ-038 Reset mid-transfer SHALL abandon the command without any rdy pulse, and read data returned after reset SHALL be dropped per REQ-032.

Verification
REQ-039 Single write: wr_en=0, wr_addr=5, wr_data=0xDEADBEEF, waitrequest=0 -> avl_write=1 with address 5 and data 0xDEADBEEF for 1 cycle; wr_rdy pulses on the next cycle; next grant is no earlier than 3 cycles after the first.
REQ-040 Stall: waitrequest=1 for 4 cycles during a read of address 2 -> avl_read and avl_address=2 are held for 5 cycles; a single rd_rdy pulse follows.
REQ-041 Contention: wr_en=0 and rd_en=0 held from reset -> grants alternate W,R,W,R with one rdy pulse each.
REQ-042 Pending limit: MAX_PEND=4, readdatavalid withheld, rd_en held low -> exactly 4 reads are issued and the 5th waits; one readdatavalid (0x11) -> rd_data=0x11 with valid, then the 5th read issues.
REQ-043 Simultaneous: read acceptance and readdatavalid on the same edge with count 2 -> count stays 2.
REQ-044 Reset during WR with waitrequest=1 -> all outputs 0 on the next cycle; a stray readdatavalid after reset -> rd_data_valid stays 0.
